// File: rtl/uart_pwm_pkg.sv
// Shared definitions for the UART command controller that configures the PWM
// generator: ASCII byte constants, parser FSM states, reply selection codes
// and small helper functions used by the parser and the reply ROM.
package uart_pwm_pkg;

    // ASCII bytes recognised by the line parser
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_H    = 8'h48;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_P    = 8'h50;

    // Largest accepted duty argument (percent)
    localparam int unsigned DUTY_MAX    = 100;

    // Byte index width into the reply ROM (longest reply is 16 bytes)
    localparam int          REPLY_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG_D,
        ST_ARG_F,
        ST_KW_H,
        ST_ERR_SKIP,
        ST_REPLY
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK,
        RSP_ERR,
        RSP_HELP
    } rsp_sel_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // Character expected after 'H' at each match position of "HELP"
    function automatic logic [7:0] help_kw_char(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = ASCII_E;
            2'd1:    c = ASCII_L;
            2'd2:    c = ASCII_P;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_reply_rom.sv
// Constant reply text for the command controller.
// Ports:
//   sel      in  reply selection (OK / ERR / HELP)
//   idx      in  byte index within the selected reply
//   rom_byte out byte at idx (0 when idx is past the end)
//   rom_last out 1 when idx addresses the final byte of the reply
// Purely combinational; the caller registers the outputs.
module uart_reply_rom
    import uart_pwm_pkg::*;
(
    input  rsp_sel_e                 sel,
    input  logic [REPLY_IDX_W-1:0]   idx,
    output logic [7:0]               rom_byte,
    output logic                     rom_last
);

    localparam int OK_LEN   = 3;
    localparam int ERR_LEN  = 4;
    localparam int HELP_LEN = 16;

    localparam logic [8*OK_LEN-1:0]   OK_TEXT   = "OK\n";
    localparam logic [8*ERR_LEN-1:0]  ERR_TEXT  = "ERR\n";
    localparam logic [8*HELP_LEN-1:0] HELP_TEXT = "D0-100 F1-65535\n";

    logic [7:0] ok_bytes   [OK_LEN];
    logic [7:0] err_bytes  [ERR_LEN];
    logic [7:0] help_bytes [HELP_LEN];

    // Unpack the strings so that index 0 is the first character sent
    generate
        for (genvar gi = 0; gi < OK_LEN; gi++) begin : g_ok
            assign ok_bytes[gi] = OK_TEXT[8*(OK_LEN-1-gi) +: 8];
        end
        for (genvar gi = 0; gi < ERR_LEN; gi++) begin : g_err
            assign err_bytes[gi] = ERR_TEXT[8*(ERR_LEN-1-gi) +: 8];
        end
        for (genvar gi = 0; gi < HELP_LEN; gi++) begin : g_help
            assign help_bytes[gi] = HELP_TEXT[8*(HELP_LEN-1-gi) +: 8];
        end
    endgenerate

    always_comb begin
        rom_byte = 8'h00;
        rom_last = 1'b0;
        case (sel)
            RSP_OK: begin
                if (idx < REPLY_IDX_W'(OK_LEN))
                    rom_byte = ok_bytes[idx[1:0]];
                rom_last = (idx == REPLY_IDX_W'(OK_LEN - 1));
            end
            RSP_ERR: begin
                if (idx < REPLY_IDX_W'(ERR_LEN))
                    rom_byte = err_bytes[idx[1:0]];
                rom_last = (idx == REPLY_IDX_W'(ERR_LEN - 1));
            end
            RSP_HELP: begin
                if (idx < REPLY_IDX_W'(HELP_LEN))
                    rom_byte = help_bytes[idx[3:0]];
                rom_last = (idx == REPLY_IDX_W'(HELP_LEN - 1));
            end
            default: begin
                rom_byte = 8'h00;
                rom_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// Command sequencer between the UART byte interface and the PWM generator.
// Parses ASCII line commands on the fly (D<n> duty, F<n> frequency, HELP),
// updates the PWM configuration and streams a text reply back.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   rx_data/rx_valid       received byte, 1-cycle strobe
//   tx_data/tx_valid/tx_ready  reply byte stream (valid/ready handshake)
//   duty_pct     PWM duty in percent (0..100)
//   freq_khz     PWM frequency in kHz (1..FREQ_MAX)
//   cfg_update   1-cycle pulse when duty_pct/freq_khz are written
//   rx_drop      1-cycle pulse when a byte arrives while a reply is sent
module uart_pwm_cmd_ctrl
    import uart_pwm_pkg::*;
#(
    parameter int unsigned DUTY_RST   = 50,
    parameter int unsigned FREQ_RST   = 1,
    parameter int unsigned FREQ_MAX   = 65535,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [6:0]  duty_pct,
    output logic [15:0] freq_khz,
    output logic        cfg_update,
    output logic        rx_drop
);

    localparam int          NDIG_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [16:0] ACC_SAT = 17'h1FFFF;

    state_e                   state_reg;
    logic [16:0]              acc_reg;
    logic [NDIG_W-1:0]        ndig_reg;
    logic [1:0]               kw_idx_reg;
    rsp_sel_e                 rsp_sel_reg;
    logic [REPLY_IDX_W-1:0]   byte_idx_reg;
    logic                     tx_last_reg;

    // Accumulator update with saturation so an overlong argument never wraps
    // back into the legal range.
    logic [20:0] acc_mult;
    logic [16:0] acc_next;
    assign acc_mult = ({4'd0, acc_reg} * 21'd10) + {17'd0, rx_data[3:0]};
    assign acc_next = (acc_mult > {4'd0, ACC_SAT}) ? ACC_SAT : acc_mult[16:0];

    logic rx_is_eol;
    logic rx_is_cr;
    assign rx_is_eol = rx_valid && (rx_data == ASCII_LF);
    assign rx_is_cr  = (rx_data == ASCII_CR);

    // End-of-line decode: decides whether a reply starts this cycle, which
    // text it uses and whether the configuration is written.
    logic     reply_start;
    rsp_sel_e reply_sel_start;
    logic     duty_wr;
    logic     freq_wr;

    always_comb begin
        reply_start     = 1'b0;
        reply_sel_start = RSP_ERR;
        duty_wr         = 1'b0;
        freq_wr         = 1'b0;
        if (rx_is_eol) begin
            case (state_reg)
                ST_ARG_D: begin
                    reply_start = 1'b1;
                    if ((ndig_reg != '0) && (acc_reg <= 17'(DUTY_MAX))) begin
                        duty_wr         = 1'b1;
                        reply_sel_start = RSP_OK;
                    end
                end
                ST_ARG_F: begin
                    reply_start = 1'b1;
                    if ((ndig_reg != '0) && (acc_reg >= 17'd1) &&
                        (acc_reg <= 17'(FREQ_MAX))) begin
                        freq_wr         = 1'b1;
                        reply_sel_start = RSP_OK;
                    end
                end
                ST_KW_H: begin
                    // A line ending before the full keyword is a mismatch
                    reply_start = 1'b1;
                    if (kw_idx_reg == 2'd3)
                        reply_sel_start = RSP_HELP;
                end
                ST_ERR_SKIP: begin
                    reply_start = 1'b1;
                end
                default: begin
                    reply_start = 1'b0;
                end
            endcase
        end
    end

    // One ROM serves both the first byte of a new reply and the following
    // byte of the reply in progress, so tx_data can be registered.
    rsp_sel_e               rom_sel;
    logic [REPLY_IDX_W-1:0] rom_idx;
    logic [7:0]             rom_byte;
    logic                   rom_last;

    assign rom_sel = (state_reg == ST_REPLY) ? rsp_sel_reg : reply_sel_start;
    assign rom_idx = (state_reg == ST_REPLY) ? (byte_idx_reg + REPLY_IDX_W'(1))
                                             : '0;

    uart_reply_rom u_reply_rom (
        .sel      (rom_sel),
        .idx      (rom_idx),
        .rom_byte (rom_byte),
        .rom_last (rom_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            ndig_reg     <= '0;
            kw_idx_reg   <= '0;
            rsp_sel_reg  <= RSP_ERR;
            byte_idx_reg <= '0;
            tx_last_reg  <= 1'b0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            duty_pct     <= 7'(DUTY_RST);
            freq_khz     <= 16'(FREQ_RST);
            cfg_update   <= 1'b0;
            rx_drop      <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            rx_drop    <= 1'b0;

            if (duty_wr) begin
                duty_pct   <= acc_reg[6:0];
                cfg_update <= 1'b1;
            end
            if (freq_wr) begin
                freq_khz   <= acc_reg[15:0];
                cfg_update <= 1'b1;
            end

            if (reply_start) begin
                state_reg    <= ST_REPLY;
                rsp_sel_reg  <= reply_sel_start;
                byte_idx_reg <= '0;
                tx_valid     <= 1'b1;
                tx_data      <= rom_byte;
                tx_last_reg  <= rom_last;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            if (rx_data == ASCII_D) begin
                                state_reg <= ST_ARG_D;
                            end else if (rx_data == ASCII_F) begin
                                state_reg <= ST_ARG_F;
                            end else if (rx_data == ASCII_H) begin
                                state_reg  <= ST_KW_H;
                                kw_idx_reg <= '0;
                            end else if (!rx_is_cr && (rx_data != ASCII_LF)) begin
                                state_reg <= ST_ERR_SKIP;
                            end
                        end
                    end

                    ST_ARG_D, ST_ARG_F: begin
                        if (rx_valid && !rx_is_cr) begin
                            if (is_digit(rx_data)) begin
                                if (ndig_reg == NDIG_W'(MAX_DIGITS)) begin
                                    state_reg <= ST_ERR_SKIP;
                                end else begin
                                    acc_reg  <= acc_next;
                                    ndig_reg <= ndig_reg + NDIG_W'(1);
                                end
                            end else begin
                                state_reg <= ST_ERR_SKIP;
                            end
                        end
                    end

                    ST_KW_H: begin
                        if (rx_valid && !rx_is_cr) begin
                            if ((kw_idx_reg != 2'd3) &&
                                (rx_data == help_kw_char(kw_idx_reg))) begin
                                kw_idx_reg <= kw_idx_reg + 2'd1;
                            end else begin
                                state_reg <= ST_ERR_SKIP;
                            end
                        end
                    end

                    ST_ERR_SKIP: begin
                        // Wait for end of line; handled by the EOL decode
                    end

                    ST_REPLY: begin
                        // No parsing while replying: every byte is discarded,
                        // including one arriving with the final acceptance.
                        if (rx_valid)
                            rx_drop <= 1'b1;
                        if (tx_valid && tx_ready) begin
                            if (tx_last_reg) begin
                                state_reg    <= ST_IDLE;
                                tx_valid     <= 1'b0;
                                tx_data      <= 8'h00;
                                acc_reg      <= '0;
                                ndig_reg     <= '0;
                                kw_idx_reg   <= '0;
                                byte_idx_reg <= '0;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + REPLY_IDX_W'(1);
                                tx_data      <= rom_byte;
                                tx_last_reg  <= rom_last;
                            end
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
module tb_uart_pwm_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [6:0]  duty_pct;
    logic [15:0] freq_khz;
    logic        cfg_update;
    logic        rx_drop;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    int         cfg_cnt  = 0;
    int         drop_cnt = 0;
    bit         rand_ready = 1'b0;

    uart_pwm_cmd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .duty_pct   (duty_pct),
        .freq_khz   (freq_khz),
        .cfg_update (cfg_update),
        .rx_drop    (rx_drop)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor: sample on the falling edge; a byte is accepted at the next
    // rising edge when tx_valid && tx_ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        bad++;
                        $display("FAIL tx_byte: got 0x%02h required 0x%02h", tx_data, e);
                    end else begin
                        $display("tx byte 0x%02h ok", tx_data);
                    end
                end
            end
            if (rst_n && cfg_update) begin
                cfg_cnt++;
                total++;
                if (tx_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL cfg_with_tx: tx_valid=%b required 1 in cfg_update cycle", tx_valid);
                end
            end
            if (rst_n && rx_drop)
                drop_cnt++;
        end
    end

    // Optional random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready)
                tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back(s[i]);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && tx_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_%s: %0d bytes still expected, tx_valid=%b, required drained", name, exp_q.size(), tx_valid);
            exp_q.delete();
        end
    endtask

    task automatic run_cmd(input string cmd, input string reply);
        push_exp(reply);
        for (int i = 0; i < cmd.len(); i++)
            send_byte(cmd[i]);
        wait_drain(cmd, 400);
        $display("command %s done: duty=%0d freq=%0d", cmd, duty_pct, freq_khz);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (duty_pct !== 7'd50) begin bad++; $display("FAIL reset_duty: got %0d required 50", duty_pct); end
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL reset_freq: got %0d required 1", freq_khz); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got 0x%02h required 0x00", tx_data); end
        total++; if (cfg_update !== 1'b0 || rx_drop !== 1'b0) begin bad++; $display("FAIL reset_pulses: cfg_update=%b rx_drop=%b required 0 0", cfg_update, rx_drop); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset checked");
    endtask

    task automatic test_duty();
        int c0;
        c0 = cfg_cnt;
        run_cmd("D75\n", "OK\n");
        total++; if (duty_pct !== 7'd75) begin bad++; $display("FAIL duty_75: got %0d required 75", duty_pct); end
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL duty_freq_keep: got %0d required 1", freq_khz); end
        total++; if (cfg_cnt - c0 !== 1) begin bad++; $display("FAIL duty_cfg_pulses: got %0d required 1", cfg_cnt - c0); end
    endtask

    task automatic test_errors();
        int c0;
        c0 = cfg_cnt;
        run_cmd("D101\n", "ERR\n");
        run_cmd("D\n", "ERR\n");
        run_cmd("F0\n", "ERR\n");
        run_cmd("HELX\n", "ERR\n");
        run_cmd("D123456\n", "ERR\n");
        run_cmd("Q7\n", "ERR\n");
        run_cmd("F65536\n", "ERR\n");
        run_cmd("D5x\n", "ERR\n");
        run_cmd("\n", "");
        total++; if (duty_pct !== 7'd75) begin bad++; $display("FAIL err_duty_keep: got %0d required 75", duty_pct); end
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL err_freq_keep: got %0d required 1", freq_khz); end
        total++; if (cfg_cnt !== c0) begin bad++; $display("FAIL err_no_cfg: got %0d pulses required 0", cfg_cnt - c0); end
    endtask

    task automatic test_freq();
        run_cmd("F20\015\n", "OK\n");
        total++; if (freq_khz !== 16'd20) begin bad++; $display("FAIL freq_20: got %0d required 20", freq_khz); end
        run_cmd("F65535\n", "OK\n");
        total++; if (freq_khz !== 16'd65535) begin bad++; $display("FAIL freq_max: got %0d required 65535", freq_khz); end
        run_cmd("D100\n", "OK\n");
        total++; if (duty_pct !== 7'd100) begin bad++; $display("FAIL duty_100: got %0d required 100", duty_pct); end
        run_cmd("D0\n", "OK\n");
        total++; if (duty_pct !== 7'd0) begin bad++; $display("FAIL duty_0: got %0d required 0", duty_pct); end
        run_cmd("F1\n", "OK\n");
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL freq_1: got %0d required 1", freq_khz); end
        run_cmd("D6\0155\n", "OK\n");
        total++; if (duty_pct !== 7'd65) begin bad++; $display("FAIL duty_cr_mid: got %0d required 65", duty_pct); end
    endtask

    task automatic test_help();
        int c0;
        c0 = cfg_cnt;
        run_cmd("HELP\n", "D0-100 F1-65535\n");
        run_cmd("HELPX\n", "ERR\n");
        total++; if (cfg_cnt !== c0) begin bad++; $display("FAIL help_no_cfg: got %0d pulses required 0", cfg_cnt - c0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_data;
        bit         stable;
        bit         seen_lf;
        int         d0;
        d0 = drop_cnt;
        tx_ready = 1'b0;
        push_exp("OK\n");
        send_byte("D");
        send_byte("3");
        send_byte("3");
        send_byte(8'h0A);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL bp_tx_valid: got %b required 1", tx_valid); end
        held_data = tx_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)
                send_byte("D");
            else begin
                @(posedge clk);
                #1;
            end
            if (tx_valid !== 1'b1 || tx_data !== held_data)
                stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL bp_stable: tx changed to valid=%b data=0x%02h, required held 0x%02h", tx_valid, tx_data, held_data); end
        total++; if (drop_cnt - d0 !== 1) begin bad++; $display("FAIL bp_rx_drop: got %0d pulses required 1", drop_cnt - d0); end
        total++; if (duty_pct !== 7'd33) begin bad++; $display("FAIL bp_duty: got %0d required 33", duty_pct); end
        // Release and send a byte exactly with the final acceptance
        tx_ready = 1'b1;
        seen_lf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid === 1'b1 && tx_data === 8'h0A) begin
                seen_lf = 1'b1;
                send_byte("D");
                break;
            end
            @(posedge clk);
            #1;
        end
        total++; if (!seen_lf) begin bad++; $display("FAIL bp_last_byte: final byte not seen, required 0x0a"); end
        wait_drain("bp", 100);
        @(posedge clk);
        #1;
        total++; if (drop_cnt - d0 !== 2) begin bad++; $display("FAIL bp_drop_last: got %0d pulses required 2", drop_cnt - d0); end
        run_cmd("D44\n", "OK\n");
        total++; if (duty_pct !== 7'd44) begin bad++; $display("FAIL bp_after: got %0d required 44", duty_pct); end
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        run_cmd("D5\n", "OK\n");
        run_cmd("HELP\n", "D0-100 F1-65535\n");
        run_cmd("F300\n", "OK\n");
        run_cmd("X\n", "ERR\n");
        run_cmd("D99\n", "OK\n");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        total++; if (duty_pct !== 7'd99) begin bad++; $display("FAIL b2b_duty: got %0d required 99", duty_pct); end
        total++; if (freq_khz !== 16'd300) begin bad++; $display("FAIL b2b_freq: got %0d required 300", freq_khz); end
    endtask

    task automatic test_reset_mid_reply();
        tx_ready = 1'b0;
        send_byte("D");
        send_byte("8");
        send_byte("8");
        send_byte(8'h0A);
        total++; if (tx_valid !== 1'b1 || duty_pct !== 7'd88) begin bad++; $display("FAIL mid_pre: tx_valid=%b duty=%0d required 1 88", tx_valid, duty_pct); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid: got %b required 0", tx_valid); end
        total++; if (duty_pct !== 7'd50) begin bad++; $display("FAIL mid_duty: got %0d required 50", duty_pct); end
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL mid_freq: got %0d required 1", freq_khz); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        run_cmd("D10\n", "OK\n");
        total++; if (duty_pct !== 7'd10) begin bad++; $display("FAIL mid_after_duty: got %0d required 10", duty_pct); end
        total++; if (freq_khz !== 16'd1) begin bad++; $display("FAIL mid_after_freq: got %0d required 1", freq_khz); end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_errors();
        test_freq();
        test_help();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_reply();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d bytes still expected, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
